// File: rtl/rv64g_l2_probe_ctrl.sv
// Coherence probe sequencer: reads a directory entry for one Acquire and probes the other
// holders. It then collects their ProbeAcks and writes back an invariant-safe entry.
module rv64g_l2_probe_ctrl #(
    parameter int SETS  = 256,
    parameter int WAYS  = 16,
    parameter int CORES = 4,
    localparam int CW = $clog2(CORES),
    localparam int SW = $clog2(SETS),
    localparam int WW = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [SW-1:0]         req_set_i,
    input  logic [WW-1:0]         req_way_i,
    input  logic [CW-1:0]         req_core_i,
    input  logic                  req_grow_t_i,
    output logic [SW-1:0]         dir_rd_set_o,
    input  logic [WAYS-1:0]       dir_valid_i,
    input  logic [WAYS*CORES-1:0] dir_sharers_i,
    input  logic [WAYS-1:0]       dir_owner_valid_i,
    input  logic [WAYS*CW-1:0]    dir_owner_id_i,
    input  logic [WAYS-1:0]       dir_dirty_i,
    output logic                  probe_valid_o,
    input  logic                  probe_ready_i,
    output logic [CW-1:0]         probe_core_o,
    output logic                  probe_to_n_o,
    input  logic                  pack_valid_i,
    input  logic [CW-1:0]         pack_core_i,
    input  logic                  pack_data_i,
    output logic                  dir_we_o,
    output logic [SW-1:0]         dir_wr_set_o,
    output logic [WW-1:0]         dir_wr_way_o,
    output logic                  dir_wr_valid_o,
    output logic [CORES-1:0]      dir_wr_sharers_o,
    output logic                  dir_wr_owner_valid_o,
    output logic [CW-1:0]         dir_wr_owner_id_o,
    output logic                  dir_wr_dirty_o,
    output logic                  done_valid_o,
    output logic                  done_dirty_o
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_PROBE, S_UPDATE} state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    set_q, set_d;
    logic [WW-1:0]    way_q, way_d;
    logic [CW-1:0]    core_q, core_d;
    logic             grow_t_q, grow_t_d;
    logic             old_valid_q, old_valid_d;
    logic [CORES-1:0] old_sharers_q, old_sharers_d;
    logic             old_owner_valid_q, old_owner_valid_d;
    logic [CW-1:0]    old_owner_id_q, old_owner_id_d;
    logic             old_dirty_q, old_dirty_d;
    logic [CORES-1:0] mask_q, mask_d;
    logic [CORES-1:0] sent_q, sent_d;
    logic [CORES-1:0] pending_q, pending_d;
    logic             data_seen_q, data_seen_d;

    logic             sel_valid, sel_owner_valid, sel_dirty;
    logic [CORES-1:0] sel_sharers, sel_owner_oh, req_oh, rd_mask, unsent;
    logic [CW-1:0]    sel_owner_id, next_probe;

    function automatic logic [CW-1:0] lowest_idx(input logic [CORES-1:0] v);
        lowest_idx = '0;
        for (int i = CORES - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = CW'(i);
        end
    endfunction

    assign sel_valid       = dir_valid_i[way_q];
    assign sel_sharers     = dir_sharers_i[way_q*CORES +: CORES];
    assign sel_owner_valid = dir_owner_valid_i[way_q];
    assign sel_owner_id    = dir_owner_id_i[way_q*CW +: CW];
    assign sel_dirty       = dir_dirty_i[way_q];
    assign sel_owner_oh    = sel_owner_valid ? (CORES'(1) << sel_owner_id) : '0;
    assign req_oh          = CORES'(1) << core_q;
    assign unsent          = mask_q & ~sent_q;
    assign next_probe      = lowest_idx(unsent);

    // toT evicts every other holder; toB only has to demote a foreign owner.
    always_comb begin
        rd_mask = '0;
        if (sel_valid) begin
            if (grow_t_q)
                rd_mask = (sel_sharers | sel_owner_oh) & ~req_oh;
            else if (sel_owner_valid && (sel_owner_id != core_q))
                rd_mask = sel_owner_oh;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d              = state_q;
        set_d                = set_q;
        way_d                = way_q;
        core_d               = core_q;
        grow_t_d             = grow_t_q;
        old_valid_d          = old_valid_q;
        old_sharers_d        = old_sharers_q;
        old_owner_valid_d    = old_owner_valid_q;
        old_owner_id_d       = old_owner_id_q;
        old_dirty_d          = old_dirty_q;
        mask_d               = mask_q;
        sent_d               = sent_q;
        pending_d            = pending_q;
        data_seen_d          = data_seen_q;
        req_ready_o          = 1'b0;
        dir_rd_set_o         = '0;
        probe_valid_o        = 1'b0;
        probe_core_o         = '0;
        probe_to_n_o         = 1'b0;
        dir_we_o             = 1'b0;
        dir_wr_set_o         = '0;
        dir_wr_way_o         = '0;
        dir_wr_valid_o       = 1'b0;
        dir_wr_sharers_o     = '0;
        dir_wr_owner_valid_o = 1'b0;
        dir_wr_owner_id_o    = '0;
        dir_wr_dirty_o       = 1'b0;
        done_valid_o         = 1'b0;
        done_dirty_o         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    set_d    = req_set_i;
                    way_d    = req_way_i;
                    core_d   = req_core_i;
                    grow_t_d = req_grow_t_i;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                dir_rd_set_o      = set_q;
                // Fields of an invalid entry are garbage; zero them so they never leak into the write.
                old_valid_d       = sel_valid;
                old_sharers_d     = sel_valid ? sel_sharers : '0;
                old_owner_valid_d = sel_valid & sel_owner_valid;
                old_owner_id_d    = sel_owner_id;
                old_dirty_d       = sel_valid & sel_dirty;
                mask_d            = rd_mask;
                pending_d         = rd_mask;
                sent_d            = '0;
                data_seen_d       = 1'b0;
                state_d           = (rd_mask != '0) ? S_PROBE : S_UPDATE;
            end
            S_PROBE: begin
                probe_valid_o = (unsent != '0);
                probe_core_o  = probe_valid_o ? next_probe : '0;
                probe_to_n_o  = probe_valid_o & grow_t_q;
                if (probe_valid_o && probe_ready_i)
                    sent_d = sent_q | (CORES'(1) << next_probe);
                if (pack_valid_i && sent_q[pack_core_i] && pending_q[pack_core_i]) begin
                    pending_d[pack_core_i] = 1'b0;
                    data_seen_d            = data_seen_q | pack_data_i;
                end
                if (pending_q == '0)
                    state_d = S_UPDATE;
            end
            S_UPDATE: begin
                dir_we_o       = 1'b1;
                done_valid_o   = 1'b1;
                done_dirty_o   = old_valid_q & (old_dirty_q | data_seen_q);
                dir_wr_set_o   = set_q;
                dir_wr_way_o   = way_q;
                dir_wr_valid_o = 1'b1;
                if (grow_t_q) begin
                    dir_wr_owner_valid_o = 1'b1;
                    dir_wr_owner_id_o    = core_q;
                    dir_wr_dirty_o       = old_dirty_q | data_seen_q;
                end else begin
                    dir_wr_sharers_o = old_sharers_q | req_oh
                                     | (old_owner_valid_q ? (CORES'(1) << old_owner_id_q) : '0);
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            set_q             <= '0;
            way_q             <= '0;
            core_q            <= '0;
            grow_t_q          <= 1'b0;
            old_valid_q       <= 1'b0;
            old_sharers_q     <= '0;
            old_owner_valid_q <= 1'b0;
            old_owner_id_q    <= '0;
            old_dirty_q       <= 1'b0;
            mask_q            <= '0;
            sent_q            <= '0;
            pending_q         <= '0;
            data_seen_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            set_q             <= set_d;
            way_q             <= way_d;
            core_q            <= core_d;
            grow_t_q          <= grow_t_d;
            old_valid_q       <= old_valid_d;
            old_sharers_q     <= old_sharers_d;
            old_owner_valid_q <= old_owner_valid_d;
            old_owner_id_q    <= old_owner_id_d;
            old_dirty_q       <= old_dirty_d;
            mask_q            <= mask_d;
            sent_q            <= sent_d;
            pending_q         <= pending_d;
            data_seen_q       <= data_seen_d;
        end
    end

endmodule

// File: tb/tb_rv64g_l2_probe_ctrl.sv
// Scoreboard bench for rv64g_l2_probe_ctrl: directed Acquires push expected probes and
// directory writes into queues, and a negedge monitor pops and compares them.
module tb_rv64g_l2_probe_ctrl;

    localparam int SW = 8, WW = 4, CW = 2, CORES = 4, WAYS = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic req_valid_i, req_ready_o, req_grow_t_i;
    logic [SW-1:0] req_set_i, dir_rd_set_o, dir_wr_set_o;
    logic [WW-1:0] req_way_i, dir_wr_way_o;
    logic [CW-1:0] req_core_i, probe_core_o, pack_core_i, dir_wr_owner_id_o;
    logic [WAYS-1:0] dir_valid_i, dir_owner_valid_i, dir_dirty_i;
    logic [WAYS*CORES-1:0] dir_sharers_i;
    logic [WAYS*CW-1:0] dir_owner_id_i;
    logic probe_valid_o, probe_ready_i, probe_to_n_o;
    logic pack_valid_i, pack_data_i;
    logic dir_we_o, dir_wr_valid_o, dir_wr_owner_valid_o, dir_wr_dirty_o;
    logic [CORES-1:0] dir_wr_sharers_o;
    logic done_valid_o, done_dirty_o;

    always #5 clk = ~clk;

    rv64g_l2_probe_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_set_i(req_set_i), .req_way_i(req_way_i), .req_core_i(req_core_i),
        .req_grow_t_i(req_grow_t_i), .dir_rd_set_o(dir_rd_set_o),
        .dir_valid_i(dir_valid_i), .dir_sharers_i(dir_sharers_i),
        .dir_owner_valid_i(dir_owner_valid_i), .dir_owner_id_i(dir_owner_id_i),
        .dir_dirty_i(dir_dirty_i), .probe_valid_o(probe_valid_o),
        .probe_ready_i(probe_ready_i), .probe_core_o(probe_core_o),
        .probe_to_n_o(probe_to_n_o), .pack_valid_i(pack_valid_i),
        .pack_core_i(pack_core_i), .pack_data_i(pack_data_i),
        .dir_we_o(dir_we_o), .dir_wr_set_o(dir_wr_set_o), .dir_wr_way_o(dir_wr_way_o),
        .dir_wr_valid_o(dir_wr_valid_o), .dir_wr_sharers_o(dir_wr_sharers_o),
        .dir_wr_owner_valid_o(dir_wr_owner_valid_o), .dir_wr_owner_id_o(dir_wr_owner_id_o),
        .dir_wr_dirty_o(dir_wr_dirty_o), .done_valid_o(done_valid_o),
        .done_dirty_o(done_dirty_o)
    );

    typedef struct {
        logic [SW-1:0]    set;
        logic [WW-1:0]    way;
        logic [CORES-1:0] sharers;
        logic             owner_valid;
        logic [CW-1:0]    owner_id;
        logic             dirty;
        logic             done_dirty;
    } wr_exp_t;

    typedef struct {
        logic [CW-1:0] core;
        logic          to_n;
    } probe_exp_t;

    wr_exp_t    wr_q[$];
    probe_exp_t probe_q[$];
    int checks = 0, failures = 0;
    int done_cnt = 0, probe_cnt = 0, exp_done = 0;

    // Directory model: only the addressed set/way holds the test entry, all else is junk.
    logic [SW-1:0] cur_set;
    logic [WW-1:0] cur_way;
    logic e_valid, e_ov, e_dirty;
    logic [CORES-1:0] e_sharers;
    logic [CW-1:0] e_id;

    always_comb begin
        dir_valid_i       = '1;
        dir_sharers_i     = '1;
        dir_owner_valid_i = '1;
        dir_owner_id_i    = '1;
        dir_dirty_i       = '1;
        if (dir_rd_set_o == cur_set) begin
            dir_valid_i[cur_way]                = e_valid;
            dir_sharers_i[cur_way*CORES +: CORES] = e_sharers;
            dir_owner_valid_i[cur_way]          = e_ov;
            dir_owner_id_i[cur_way*CW +: CW]    = e_id;
            dir_dirty_i[cur_way]                = e_dirty;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (probe_valid_o && probe_ready_i) begin
                probe_cnt++;
                if (probe_q.size() == 0) begin
                    timeout("unexpected_probe");
                end else begin
                    probe_exp_t p;
                    p = probe_q.pop_front();
                    check("probe_core", 32'(probe_core_o), 32'(p.core));
                    check("probe_to_n", 32'(probe_to_n_o), 32'(p.to_n));
                end
            end
            if (done_valid_o) done_cnt++;
            if (dir_we_o || done_valid_o) begin
                check("we_done_together", 32'(dir_we_o), 32'(done_valid_o));
                if (wr_q.size() == 0) begin
                    timeout("unexpected_dir_write");
                end else begin
                    wr_exp_t w;
                    w = wr_q.pop_front();
                    check("wr_set", 32'(dir_wr_set_o), 32'(w.set));
                    check("wr_way", 32'(dir_wr_way_o), 32'(w.way));
                    check("wr_valid", 32'(dir_wr_valid_o), 32'(1));
                    check("wr_sharers", 32'(dir_wr_sharers_o), 32'(w.sharers));
                    check("wr_owner_valid", 32'(dir_wr_owner_valid_o), 32'(w.owner_valid));
                    check("wr_owner_id", 32'(dir_wr_owner_id_o), 32'(w.owner_id));
                    check("wr_dirty", 32'(dir_wr_dirty_o), 32'(w.dirty));
                    check("done_dirty", 32'(done_dirty_o), 32'(w.done_dirty));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input logic [SW-1:0] s, input logic [WW-1:0] w, input logic v,
                             input logic [CORES-1:0] sh, input logic ov,
                             input logic [CW-1:0] id, input logic d);
        cur_set = s; cur_way = w; e_valid = v; e_sharers = sh; e_ov = ov; e_id = id; e_dirty = d;
    endtask

    task automatic push_wr(input logic [CORES-1:0] sh, input logic ov, input logic [CW-1:0] id,
                           input logic d, input logic dd);
        wr_exp_t w;
        w.set = cur_set; w.way = cur_way; w.sharers = sh; w.owner_valid = ov;
        w.owner_id = id; w.dirty = d; w.done_dirty = dd;
        wr_q.push_back(w);
        exp_done++;
    endtask

    task automatic push_probe(input logic [CW-1:0] c, input logic to_n);
        probe_exp_t p;
        p.core = c; p.to_n = to_n;
        probe_q.push_back(p);
    endtask

    // Presents the request and returns just after the accepting edge.
    task automatic issue(input logic [CW-1:0] core, input logic grow_t);
        int n = 0;
        while (!req_ready_o && n < 50) begin tick(); n++; end
        if (!req_ready_o) timeout("req_ready");
        req_set_i = cur_set; req_way_i = cur_way; req_core_i = core; req_grow_t_i = grow_t;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt < exp_done && n < 50) begin tick(); n++; end
        if (done_cnt < exp_done) timeout("wait_done");
    endtask

    task automatic wait_probes(input int target);
        int n = 0;
        while (probe_cnt < target && n < 50) begin tick(); n++; end
        if (probe_cnt < target) timeout("wait_probes");
    endtask

    task automatic wait_probe_valid();
        int n = 0;
        while (!probe_valid_o && n < 50) begin tick(); n++; end
        if (!probe_valid_o) timeout("wait_probe_valid");
    endtask

    task automatic ack(input logic [CW-1:0] c, input logic d);
        pack_valid_i = 1'b1; pack_core_i = c; pack_data_i = d;
        tick();
        pack_valid_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid_i = 1'b0; req_set_i = '0; req_way_i = '0; req_core_i = '0;
        req_grow_t_i = 1'b0; probe_ready_i = 1'b0; pack_valid_i = 1'b0; pack_core_i = '0;
        pack_data_i = 1'b0;
        set_entry(8'h00, 4'h0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        tick(); tick();
        check("rst_req_ready", 32'(req_ready_o), 32'(1));
        check("rst_probe_valid", 32'(probe_valid_o), 32'(0));
        check("rst_dir_we", 32'(dir_we_o), 32'(0));
        check("rst_done_valid", 32'(done_valid_o), 32'(0));
        check("rst_rd_set", 32'(dir_rd_set_o), 32'(0));
        rst_n = 1'b1;
        tick();

        // 1: invalid entry (junk fields), core1 toT; no probes, exact latency.
        probe_ready_i = 1'b1;
        set_entry(8'h3c, 4'h5, 1'b0, 4'b1111, 1'b1, 2'd2, 1'b1);
        push_wr(4'b0000, 1'b1, 2'd1, 1'b0, 1'b0);
        issue(2'd1, 1'b1);
        check("lat_read_ready", 32'(req_ready_o), 32'(0));
        check("lat_read_we", 32'(dir_we_o), 32'(0));
        check("lat_rd_set", 32'(dir_rd_set_o), 32'(8'h3c));
        tick();
        check("lat_update_we", 32'(dir_we_o), 32'(1));
        check("lat_update_done", 32'(done_valid_o), 32'(1));
        tick();
        check("lat_idle_ready", 32'(req_ready_o), 32'(1));
        wait_done();

        // 2: sharers 1011, core0 toT; probes core1 then core3, acks in reverse order.
        set_entry(8'h81, 4'h9, 1'b1, 4'b1011, 1'b0, 2'd0, 1'b0);
        push_probe(2'd1, 1'b1);
        push_probe(2'd3, 1'b1);
        push_wr(4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);
        issue(2'd0, 1'b1);
        wait_probes(probe_cnt + 2);
        probe_ready_i = 1'b0;
        ack(2'd3, 1'b0);
        ack(2'd1, 1'b0);
        wait_done();

        // 3: dirty owner 2, core0 toB; one probe to_n=0, ack with data.
        set_entry(8'h12, 4'hf, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1);
        push_probe(2'd2, 1'b0);
        push_wr(4'b0101, 1'b0, 2'd0, 1'b0, 1'b1);
        probe_ready_i = 1'b1;
        issue(2'd0, 1'b0);
        wait_probes(probe_cnt + 1);
        probe_ready_i = 1'b0;
        ack(2'd2, 1'b1);
        wait_done();

        // 4: stalled probe stays stable; early and stray acks are ignored.
        set_entry(8'h40, 4'h2, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b0);
        push_probe(2'd1, 1'b1);
        push_wr(4'b0000, 1'b1, 2'd3, 1'b0, 1'b0);
        issue(2'd3, 1'b1);
        wait_probe_valid();
        pack_valid_i = 1'b1; pack_core_i = 2'd1; pack_data_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", 32'(probe_valid_o), 32'(1));
            check("stall_core", 32'(probe_core_o), 32'(1));
            check("stall_to_n", 32'(probe_to_n_o), 32'(1));
            tick();
            pack_valid_i = 1'b0;
        end
        probe_ready_i = 1'b1;
        tick();
        probe_ready_i = 1'b0;
        ack(2'd0, 1'b1);
        ack(2'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("no_early_update", 32'(dir_we_o), 32'(0));
            tick();
        end
        check("no_early_done_cnt", 32'(done_cnt), 32'(exp_done - 1));
        ack(2'd1, 1'b0);
        wait_done();

        // 5: ack core0 (with data) in the same cycle as the last probe handshake.
        set_entry(8'h07, 4'h0, 1'b1, 4'b0011, 1'b0, 2'd0, 1'b0);
        push_probe(2'd0, 1'b1);
        push_probe(2'd1, 1'b1);
        push_wr(4'b0000, 1'b1, 2'd2, 1'b1, 1'b1);
        issue(2'd2, 1'b1);
        wait_probe_valid();
        probe_ready_i = 1'b1;
        tick();
        pack_valid_i = 1'b1; pack_core_i = 2'd0; pack_data_i = 1'b1;
        tick();
        probe_ready_i = 1'b0;
        ack(2'd1, 1'b0);
        wait_done();

        // 6: requester already owns the line, toB; no probe, owner folds into sharers.
        set_entry(8'hc5, 4'h6, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1);
        push_wr(4'b0010, 1'b0, 2'd0, 1'b0, 1'b1);
        probe_ready_i = 1'b1;
        issue(2'd1, 1'b0);
        wait_done();

        // 7: reset during PROBE abandons the transaction.
        probe_ready_i = 1'b0;
        set_entry(8'h99, 4'h3, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0);
        issue(2'd0, 1'b1);
        wait_probe_valid();
        rst_n = 1'b0;
        tick();
        check("mid_rst_ready", 32'(req_ready_o), 32'(1));
        check("mid_rst_probe_valid", 32'(probe_valid_o), 32'(0));
        check("mid_rst_we", 32'(dir_we_o), 32'(0));
        check("mid_rst_done", 32'(done_valid_o), 32'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("mid_rst_done_cnt", 32'(done_cnt), 32'(exp_done));

        // 8: normal operation after the abandoned transaction: invalid entry, core2 toB.
        set_entry(8'h55, 4'ha, 1'b0, 4'b1111, 1'b1, 2'd3, 1'b1);
        push_wr(4'b0100, 1'b0, 2'd0, 1'b0, 1'b0);
        probe_ready_i = 1'b1;
        issue(2'd2, 1'b0);
        wait_done();

        for (int i = 0; i < 3; i++) tick();
        check("wr_queue_empty", 32'(wr_q.size()), 32'(0));
        check("probe_queue_empty", 32'(probe_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
